// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle through a single shared WIDTH+1 bit adder/subtractor.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t           state;
    logic [2:0]       op;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] operand;
    logic [CW-1:0]    count;
    logic             neg_main;
    logic             neg_rem;

    logic             signed1;
    logic             signed2;
    logic             neg1;
    logic             neg2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             div_zero;
    logic             overflow;
    logic             fast;

    // Operand decode for a launch request; only consumed in IDLE.
    always_comb begin
        signed1  = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
                   (funct3 == 3'd4) || (funct3 == 3'd6);
        signed2  = (funct3 == 3'd0) || (funct3 == 3'd1) ||
                   (funct3 == 3'd4) || (funct3 == 3'd6);
        neg1     = signed1 && op1[WIDTH-1];
        neg2     = signed2 && op2[WIDTH-1];
        mag1     = neg1 ? (~op1 + WIDTH'(1)) : op1;
        mag2     = neg2 ? (~op2 + WIDTH'(1)) : op2;
        div_zero = (op2 == '0);
        overflow = !funct3[0] && (op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&op2);
        fast     = funct3[2] && (div_zero || overflow);
    end

    logic             is_div;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [WIDTH:0]   sum;

    // Shared adder: accumulates the multiplicand, or trial-subtracts the divisor
    // from the left-shifted partial remainder (sum[WIDTH] set means borrow).
    always_comb begin
        is_div = op[2];
        if (is_div) begin
            add_a = {hi, lo[WIDTH-1]};
            add_b = ~{1'b0, operand};
        end else begin
            add_a = {1'b0, hi};
            add_b = lo[0] ? {1'b0, operand} : '0;
        end
        sum = add_a + add_b + {{WIDTH{1'b0}}, is_div};
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   result_next;

    always_comb begin
        prod_fix = neg_main ? (~{hi, lo} + (2*WIDTH)'(1)) : {hi, lo};
        quo_fix  = neg_main ? (~lo + WIDTH'(1)) : lo;
        rem_fix  = neg_rem ? (~hi + WIDTH'(1)) : hi;
        case (op)
            3'd0:                result_next = prod_fix[WIDTH-1:0];
            3'd1, 3'd2, 3'd3:    result_next = prod_fix[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:          result_next = quo_fix;
            default:             result_next = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op       <= '0;
            hi       <= '0;
            lo       <= '0;
            operand  <= '0;
            count    <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start && !kill) begin
                        op    <= funct3;
                        busy  <= 1'b1;
                        count <= CW'(WIDTH - 1);
                        // Fast paths preload the final quotient (lo) and remainder (hi).
                        if (fast) begin
                            hi       <= div_zero ? op1 : '0;
                            lo       <= div_zero ? '1 : op1;
                            neg_main <= 1'b0;
                            neg_rem  <= 1'b0;
                            state    <= FINISH;
                        end else begin
                            hi       <= '0;
                            lo       <= funct3[2] ? mag1 : mag2;
                            operand  <= funct3[2] ? mag2 : mag1;
                            neg_main <= neg1 ^ neg2;
                            neg_rem  <= neg1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            hi <= sum[WIDTH] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : sum[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], ~sum[WIDTH]};
                        end else begin
                            hi <= sum[WIDTH:1];
                            lo <= {sum[0], lo[WIDTH-1:1]};
                        end
                        count <= count - CW'(1);
                        if (count == '0) begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    if (kill) begin
                        busy <= 1'b0;
                    end else begin
                        result <= result_next;
                        done   <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table plus hand-written handshake,
// reset and kill sequences, with a queue of expected results.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests = 0;
    int failed = 0;
    logic [31:0] expQ[$];
    logic [31:0] lastExp;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .funct3(funct3),
        .op1(op1),
        .op2(op2),
        .kill(kill),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    // Reference model built on 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] r;
        sa = a;
        sb = b;
        p = '0;
        r = '0;
        case (f)
            3'd0, 3'd1: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            3'd2:       p = {{32{a[31]}}, a} * {32'b0, b};
            3'd3:       p = {32'b0, a} * {32'b0, b};
            default:    p = '0;
        endcase
        if (!f[2]) begin
            r = (f == 3'd0) ? p[31:0] : p[63:32];
        end else if (b == 32'd0) begin
            r = f[1] ? a : 32'hFFFFFFFF;
        end else if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            r = f[1] ? 32'd0 : a;
        end else begin
            case (f)
                3'd4:    r = sa / sb;
                3'd5:    r = a / b;
                3'd6:    r = sa % sb;
                default: r = a % b;
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Counts edges from the current sample point until done is seen (bounded).
    task automatic waitDone(output int cyc, output bit busyOk);
        cyc = 0;
        busyOk = 1'b1;
        while (!done && cyc < 60) begin
            if (!busy) busyOk = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (!busy) busyOk = 1'b0;
    endtask

    task automatic countDones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    task automatic acceptOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        @(negedge clk);
        start = 1'b1;
        funct3 = f;
        op1 = a;
        op2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        expQ.push_back(exp);
    endtask

    task automatic applyStimulus(input string name, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        bit busyOk;
        logic [31:0] want;
        acceptOp(f, a, b, exp);
        waitDone(cyc, busyOk);
        want = expQ.pop_front();
        checkOutput({name, " latency"}, cyc, lat);
        checkOutput({name, " busy"}, {31'b0, busyOk}, 32'd1);
        checkOutput({name, " result"}, result, want);
        @(posedge clk); #1;
        checkOutput({name, " done pulse"}, {31'b0, done}, 32'd0);
        checkOutput({name, " result hold"}, result, want);
        lastExp = want;
    endtask

    initial begin
        int cyc;
        bit busyOk;
        int n;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33};
        vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[3]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[4]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[5]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
        vecs[6]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
        vecs[7]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[8]  = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
        vecs[9]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[10] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[12] = '{3'd0, 32'h80000000, 32'd3,        32'h80000000, 33};
        vecs[13] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[14] = '{3'd6, 32'd5,        32'd0,        32'd5,        1};
        vecs[15] = '{3'd1, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 33};

        reset = 1'b1;
        start = 1'b0;
        kill = 1'b0;
        funct3 = '0;
        op1 = '0;
        op2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a multiply.
        acceptOp(3'd0, 32'd7, 32'd6, 32'd42);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset done", {31'b0, done}, 32'd0);
        checkOutput("midreset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        void'(expQ.pop_front());
        countDones(40, n);
        checkOutput("midreset no done", n, 0);
        applyStimulus("post-reset MULHU", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);

        for (int i = 0; i < 16; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                          vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            applyStimulus($sformatf("rand%0d", i), rf, ra, rb, model(rf, ra, rb),
                          (rf[2] && (rb == 0 || (!rf[0] && ra == 32'h80000000 && rb == 32'hFFFFFFFF))) ? 1 : 33);
        end

        // start held high: second op must be taken only in the cycle after done.
        acceptOp(3'd0, 32'd3, 32'd4, 32'd12);
        start = 1'b1;
        op1 = 32'd5;
        op2 = 32'd6;
        waitDone(cyc, busyOk);
        checkOutput("held first latency", cyc, 33);
        checkOutput("held first result", result, expQ.pop_front());
        expQ.push_back(32'd30);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("held done pulse", {31'b0, done}, 32'd0);
        checkOutput("held accept busy", {31'b0, busy}, 32'd1);
        waitDone(cyc, busyOk);
        checkOutput("held second latency", cyc, 33);
        checkOutput("held second result", result, expQ.pop_front());

        // start pulse during CALC is ignored.
        acceptOp(3'd5, 32'd100, 32'd7, 32'd14);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        funct3 = 3'd0;
        op1 = 32'd2;
        op2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(cyc, busyOk);
        checkOutput("pulse latency", cyc, 28);
        checkOutput("pulse busy", {31'b0, busyOk}, 32'd1);
        checkOutput("pulse result", result, expQ.pop_front());
        countDones(40, n);
        checkOutput("pulse no extra done", n, 0);
        checkOutput("pulse idle busy", {31'b0, busy}, 32'd0);

        // kill during CALC keeps the previous result.
        applyStimulus("prekill MUL", 3'd0, 32'd3, 32'd4, 32'd12, 33);
        acceptOp(3'd5, 32'd100, 32'd7, 32'd14);
        repeat (4) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        void'(expQ.pop_front());
        checkOutput("kill busy", {31'b0, busy}, 32'd0);
        checkOutput("kill done", {31'b0, done}, 32'd0);
        checkOutput("kill result", result, lastExp);
        countDones(40, n);
        checkOutput("kill no done", n, 0);
        checkOutput("kill result kept", result, 32'd12);
        applyStimulus("postkill DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
